// File: rtl/shifter_if.sv
// shifter_if
//   Groups the data and control signals that pass between the ALU-side
//   driver and the MIC C-bus shifter.
//   Signals:
//     in       ALU result to be shifted (WIDTH bits)
//     sll8     request logical shift left by 8
//     sra1     request arithmetic shift right by 1
//     out      registered shifter result (WIDTH bits)
//     conflict registered flag, set when sll8 and sra1 were both requested
//   Modports:
//     master   drives in/sll8/sra1, observes out/conflict
//     slave    the shifter itself
interface shifter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in;
  logic             sll8;
  logic             sra1;
  logic [WIDTH-1:0] out;
  logic             conflict;

  modport master (
    output in,
    output sll8,
    output sra1,
    input  out,
    input  conflict
  );

  modport slave (
    input  in,
    input  sll8,
    input  sra1,
    output out,
    output conflict
  );
endinterface

// File: rtl/shifter.sv
// shifter
//   Registered MIC shifter between the ALU output and the C bus. Each rising
//   edge captures one of: pass-through, logical shift left by 8, or
//   arithmetic shift right by 1 of the ALU result. Requesting both shifts at
//   once is illegal: the value passes through unshifted and conflict is set.
//   Latency is exactly one cycle and a new value is loaded every cycle.
//   Ports:
//     clk    system clock, rising-edge active
//     rst_n  asynchronous active-low reset; clears out and conflict
//     bus    shifter_if slave modport (in, sll8, sra1 -> out, conflict)
//   Parameters:
//     WIDTH  datapath width; shift amounts are fixed, so WIDTH must be >= 9
module shifter #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  shifter_if.slave bus
);

  logic [WIDTH-1:0] next_out;
  logic             next_conflict;

  // Fully covered case with defaults first so no latch can be inferred.
  // The illegal both-asserted combination deliberately falls back to
  // pass-through so the C bus still carries a defined value.
  always_comb begin
    next_out      = bus.in;
    next_conflict = 1'b0;
    case ({bus.sll8, bus.sra1})
      2'b10: next_out = {bus.in[WIDTH-9:0], 8'h00};
      2'b01: next_out = {bus.in[WIDTH-1], bus.in[WIDTH-1:1]};
      2'b11: begin
        next_out      = bus.in;
        next_conflict = 1'b1;
      end
      default: begin
        next_out      = bus.in;
        next_conflict = 1'b0;
      end
    endcase
  end

  // Result and conflict flag are registered together so they always
  // describe the same captured operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out      <= '0;
      bus.conflict <= 1'b0;
    end else begin
      bus.out      <= next_out;
      bus.conflict <= next_conflict;
    end
  end

endmodule

// File: tb/tb_shifter.sv
// tb_shifter
//   Self-checking bench for the shifter. Expected results are pushed to a
//   scoreboard queue when stimulus is driven (on the falling edge) and popped
//   and compared one rising edge later. Reset behaviour is compared against
//   fixed constants without a clock edge.
module tb_shifter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        conflict;
  } exp_t;

  exp_t sb[$];

  shifter_if #(.WIDTH(32)) bus ();

  shifter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model written independently of the RTL slicing.
  function automatic void model(input logic [31:0] d, input logic s8,
                                input logic r1, output logic [31:0] eo,
                                output logic ec);
    eo = d;
    ec = 1'b0;
    if (s8 && r1) ec = 1'b1;
    else if (s8) eo = d << 8;
    else if (r1) eo = $unsigned($signed(d) >>> 1);
  endfunction

  // Drive one operation on the falling edge and record its expected result.
  task automatic applyStimulus(input string tag, input logic [31:0] d,
                               input logic s8, input logic r1,
                               input logic [31:0] eo, input logic ec);
    exp_t e;
    @(negedge clk);
    bus.in   = d;
    bus.sll8 = s8;
    bus.sra1 = r1;
    e.tag      = tag;
    e.out      = eo;
    e.conflict = ec;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag, input logic [31:0] ao,
                         input logic ac, input logic [31:0] eo,
                         input logic ec);
    checks++;
    assert (ao === eo) else begin
      errors++;
      $error("[TB] FAIL %s out: got %h expected %h", tag, ao, eo);
    end
    checks++;
    assert (ac === ec) else begin
      errors++;
      $error("[TB] FAIL %s conflict: got %b expected %b", tag, ac, ec);
    end
  endtask

  // One rising edge later, pop the oldest expectation and compare.
  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      compare(e.tag, bus.out, bus.conflict, e.out, e.conflict);
    end
  endtask

  initial begin
    logic [31:0] d, eo;
    logic        s8, r1, ec;

    bus.in   = 32'hFFFFFFFF;
    bus.sll8 = 1'b1;
    bus.sra1 = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1 compare("reset_async", bus.out, bus.conflict, 32'h0, 1'b0);

    // Held reset ignores a rising edge
    @(posedge clk);
    #1 compare("reset_hold", bus.out, bus.conflict, 32'h0, 1'b0);

    // Release and load first value
    applyStimulus("reset_release", 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFF00, 1'b0);
    rst_n = 1'b1;
    checkOutput();

    applyStimulus("sra_neg", 32'hA123FAB2, 1'b0, 1'b1, 32'hD091FD59, 1'b0);
    checkOutput();
    applyStimulus("sll_case1", 32'hB125FFFF, 1'b1, 1'b0, 32'h25FFFF00, 1'b0);
    checkOutput();
    applyStimulus("sll_case2", 32'h3342BB21, 1'b1, 1'b0, 32'h42BB2100, 1'b0);
    checkOutput();
    applyStimulus("pass", 32'h0034AAAA, 1'b0, 1'b0, 32'h0034AAAA, 1'b0);
    checkOutput();
    applyStimulus("sra_pos", 32'h00001111, 1'b0, 1'b1, 32'h00000888, 1'b0);
    checkOutput();
    applyStimulus("conflict", 32'h12345678, 1'b1, 1'b1, 32'h12345678, 1'b1);
    checkOutput();
    applyStimulus("conflict_recover", 32'h12345678, 1'b0, 1'b1, 32'h091A2B3C, 1'b0);
    checkOutput();

    // Latency: new input every cycle, each result from the previous edge
    for (int i = 0; i < 16; i++) begin
      d  = $urandom;
      s8 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      model(d, s8, r1, eo, ec);
      applyStimulus($sformatf("latency_%0d", i), d, s8, r1, eo, ec);
      checkOutput();
    end

    // Mid-operation reset between edges clears immediately
    applyStimulus("pre_reset", 32'hCAFEBABE, 1'b1, 1'b1, 32'hCAFEBABE, 1'b1);
    checkOutput();
    #2 rst_n = 1'b0;
    #1 compare("reset_mid", bus.out, bus.conflict, 32'h0, 1'b0);
    @(negedge clk);
    bus.in   = 32'h87654321;
    bus.sll8 = 1'b0;
    bus.sra1 = 1'b1;
    @(posedge clk);
    #1 compare("reset_mid_hold", bus.out, bus.conflict, 32'h0, 1'b0);

    applyStimulus("post_reset", 32'h87654321, 1'b0, 1'b1, 32'hC3B2A190, 1'b0);
    rst_n = 1'b1;
    checkOutput();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shifter.md
Name: shifter

Overview:
- Registered 32-bit shifter for the MIC datapath. It sits between the ALU output and the C bus.
- Per the MIC-1 shifter definition, it applies one of three operations to the ALU result:
  - logical left shift by 8 (sll8)
  - arithmetic right shift by 1 (sra1)
  - pass-through
- The result is captured on the clock edge so it can drive the C bus one cycle later.
- A conflict flag reports illegal control combinations.

Parameters:
- WIDTH, 32, datapath width in bits. The shift amounts stay fixed at 8 and 1, so WIDTH must be >= 9.

Ports:
- clk  input  1  system clock; rising-edge active
- rst_n  input  1  asynchronous active-low reset
- out  output  WIDTH  registered shifter result
- sll8  input  1  request logical shift left by 8
- sra1  input  1  request arithmetic shift right by 1
- in  input  WIDTH  ALU result to be shifted
- conflict  output  1  registered flag; 1 when sll8 and sra1 were both asserted

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, out=0 and conflict=0 immediately, independent of clk. After rst_n deasserts, the first rising edge loads normally.
- Latency: exactly 1 cycle. Values sampled on rising edge N appear on out/conflict after edge N. There is no enable, so a new value is loaded every cycle.
- Combinational next-value rules:
  - sll8=0, sra1=0: next = in (pass-through).
  - sll8=1, sra1=0: next = {in[WIDTH-9:0], 8'h00}. The upper 8 bits are discarded; zeros fill from the LSB side.
  - sll8=0, sra1=1: next = {in[WIDTH-1], in[WIDTH-1:1]}. The sign bit is replicated; bit 0 is discarded.
  - sll8=1, sra1=1: illegal. next = in (pass-through) and next conflict = 1.
- conflict is 0 for all legal combinations. It is registered alongside out with the same latency.
- The shift amount is fixed; there are no variable shifts and no rotate.
- No X propagation from control: if control inputs are X/Z in simulation, behaviour is unspecified. Synthesis must use full case coverage with no latches.
- Mid-operation reset: an rst_n assertion between edges clears out and conflict immediately. Pending inputs are not captured until rst_n is high at a rising edge.

Test Plan:
- Reset: drive rst_n=0 with in=32'hFFFFFFFF and sll8=1 -> out=32'h00000000, conflict=0, with no clock edge required. Then release rst_n and apply one edge -> out=32'hFFFFFF00.
- Arithmetic right, negative value: in=32'hA123FAB2, sll8=0, sra1=1, one edge -> out=32'hD091FD59, conflict=0.
- Left by 8, case 1: in=32'hB125FFFF, sll8=1, sra1=0 -> out=32'h25FFFF00.
- Left by 8, case 2: in=32'h3342BB21, sll8=1, sra1=0 -> out=32'h42BB2100.
- Pass-through: in=32'h0034AAAA, both controls 0 -> out=32'h0034AAAA.
- Arithmetic right, positive value: in=32'h00001111, sra1=1 -> out=32'h00000888.
- Conflict, then recovery:
  - in=32'h12345678, sll8=1, sra1=1 -> out=32'h12345678, conflict=1.
  - Next cycle with a legal control -> conflict returns to 0.
- Latency check: change in every cycle and confirm out always reflects the input from the previous edge.
